tag_pool_control: RTL and testbench
===================================

# tag_pool_control

Parametrised command-tag manager between compute-unit command arbitration and the PSL command/response interfaces. It owns a free list of NUM_TAGS tags and issues one per accepted command. It stores per-tag metadata (CU ID, command type) and returns that metadata on the response and read-data paths. It tracks outstanding tags and signals idle for drain/flush sequencing.

## Interface
- TAG_WIDTH, 8, width of a tag.
- NUM_TAGS, 256, tags managed; 2 ≤ NUM_TAGS ≤ 2^TAG_WIDTH. Tags issued are 0..NUM_TAGS-1.
- META_WIDTH, 32, width of per-tag metadata word.
- CNT_WIDTH, $clog2(NUM_TAGS+1), outstanding-counter width.

Ports:
- clock  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enabled  in  1  block enable; low forces re-initialisation.
- alloc_valid  in  1  requester wants a tag this cycle.
- alloc_meta  in  META_WIDTH  metadata to bind to the issued tag.
- alloc_ready  out  1  a free tag is available; transfer occurs when alloc_valid & alloc_ready.
- alloc_tag  out  TAG_WIDTH  tag issued on transfer (head of free list).
- release_valid  in  1  PSL response returns a tag.
- release_tag  in  TAG_WIDTH  returned tag.
- release_meta_valid  out  1  registered; release accepted last cycle.
- release_meta  out  META_WIDTH  metadata of last accepted released tag.
- rd_tag  in  TAG_WIDTH  read-data tag lookup address.
- rd_meta  out  META_WIDTH  metadata for rd_tag, 1-cycle latency.
- outstanding  out  CNT_WIDTH  tags currently issued.
- init_done  out  1  free list fully populated; normal operation.
- idle  out  1  init_done & outstanding==0.
- release_err  out  1  sticky release error (see Configuration).

## Operation
- FSM states: RESET, INIT, READY.
- RESET → INIT: unconditional, one cycle.
- INIT: pushes init counter values 0..NUM_TAGS-1 into the free list, one per cycle. Transitions to READY in the cycle after tag NUM_TAGS-1 is pushed.
- READY: stays in READY while enabled.
- enabled low in any state: next state RESET. Free list is emptied, outstanding cleared, in-use bitmap cleared. Tags in flight are discarded.
- alloc_ready = READY & free list non-empty. It is 0 in RESET and INIT.
- Allocate (alloc_valid & alloc_ready):
  - pop the free-list head;
  - write alloc_meta to meta RAM at alloc_tag;
  - increment outstanding.
- Release (release_valid in READY):
  - push release_tag to the free-list tail;
  - read meta RAM at release_tag into release_meta;
  - decrement outstanding.
  - release_valid outside READY is ignored.
- Same-cycle allocate and release:
  - both take effect; outstanding unchanged;
  - alloc_tag is the pre-push head. A tag released this cycle is never issued in the same cycle; no bypass.
- Free list: circular buffer, NUM_TAGS entries, head/tail pointers wrap at NUM_TAGS. It cannot overflow when releases are legal.
- Meta RAM: NUM_TAGS × META_WIDTH. One write port, two registered read ports (release, rd_tag).
  - On a write and read of the same address in the same cycle, the read returns the old data.

## Timing
- Reset values: alloc_ready 0, alloc_tag 0, release_meta_valid 0, release_meta 0, rd_meta 0, outstanding 0, init_done 0, idle 0, release_err 0.
- alloc_tag is show-ahead, combinational from the free-list head, and valid whenever alloc_ready=1.
- First alloc_ready=1 comes NUM_TAGS+2 cycles after rstn deasserts with enabled high.
- release_meta_valid/release_meta appear 1 cycle after release_valid.
- rd_meta appears 1 cycle after rd_tag.
- outstanding, idle and init_done are registered and update the cycle after the causing event.
- After exactly NUM_TAGS allocations with no releases, alloc_ready=0 until a release is accepted. Ready returns the cycle after that release.

## Configuration
- Macro TAG_POOL_RELEASE_CHECK_EN.
- Defined:
  - keeps an in-use bitmap of NUM_TAGS bits; set on allocate, cleared on release;
  - a release of a tag not in use, or with release_tag ≥ NUM_TAGS, is dropped: no push, no counter change, release_meta_valid stays 0;
  - the dropped release sets release_err (sticky until reset or enabled low).
- Undefined: no bitmap; every release in READY is accepted unconditionally; release_err tied 0.

## Test plan
- Reset, enabled=1, NUM_TAGS=256 → init_done rises at cycle 257, alloc_ready at 258. First tags issued are 0,1,2 in order.
- 256 back-to-back allocations with meta = tag+0x100 → alloc_ready falls after the 256th, outstanding=256, idle=0.
- From full allocation, release tag 0x2A → release_meta_valid next cycle with release_meta=0x12A. Next alloc_tag=0x2A, outstanding 255.
- One tag free and alloc_valid high, release 0x05 in the same cycle → head tag issued, 0x05 not issued that cycle, outstanding unchanged.
- Drop enabled mid-traffic with outstanding=40 → outstanding=0, init_done=0 next cycle, full re-init, then tags 0.. issued again.
- With TAG_POOL_RELEASE_CHECK_EN, release never-allocated tag 0x10 → release_err=1, outstanding unchanged, no release_meta_valid. Without the macro → release accepted, release_err stays 0.

Source files
------------

// File: rtl/tag_pool_control.sv
// rtl/tag_pool_control.sv - command-tag free list, per-tag metadata store and outstanding tracking
// Optional release checking: define TAG_POOL_RELEASE_CHECK_EN.
module tag_pool_control #(
    parameter int TAG_WIDTH  = 8,
    parameter int NUM_TAGS   = 256,
    parameter int META_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(NUM_TAGS + 1)
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  enabled,
    input  logic                  alloc_valid,
    input  logic [META_WIDTH-1:0] alloc_meta,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  release_valid,
    input  logic [TAG_WIDTH-1:0]  release_tag,
    output logic                  release_meta_valid,
    output logic [META_WIDTH-1:0] release_meta,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic [META_WIDTH-1:0] rd_meta,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  init_done,
    output logic                  idle,
    output logic                  release_err
);

    localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_READY
    } state_t;

    state_t state, state_next;

    logic [TAG_WIDTH-1:0]  free_list [NUM_TAGS];
    logic [META_WIDTH-1:0] meta_ram  [NUM_TAGS];

    logic [PTR_W-1:0]     head, tail;
    logic [CNT_WIDTH-1:0] free_count, init_cnt, outstanding_q, outstanding_next;
    logic                 init_done_q, init_done_next, idle_q, release_meta_valid_q;

    logic                 is_ready, alloc_fire, rel_fire, init_push, push;
    logic [TAG_WIDTH-1:0] push_data;
    logic [PTR_W-1:0]     alloc_idx, rel_idx, rd_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_ready    = (state == ST_READY);
    assign alloc_ready = is_ready && (free_count != '0);
    assign alloc_tag   = alloc_ready ? free_list[head] : '0;
    assign alloc_idx   = PTR_W'(alloc_tag);
    assign rel_idx     = PTR_W'(release_tag);
    assign rd_idx      = PTR_W'(rd_tag);
    assign alloc_fire  = enabled && alloc_valid && alloc_ready;

`ifdef TAG_POOL_RELEASE_CHECK_EN
    logic [NUM_TAGS-1:0] in_use;
    logic                rel_hit, rel_bad, release_err_q;

    assign rel_hit     = (int'(release_tag) < NUM_TAGS) && in_use[rel_idx];
    assign rel_fire    = enabled && is_ready && release_valid && rel_hit;
    assign rel_bad     = enabled && is_ready && release_valid && !rel_hit;
    assign release_err = release_err_q;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            in_use        <= '0;
            release_err_q <= 1'b0;
        end else if (!enabled) begin
            in_use        <= '0;
            release_err_q <= 1'b0;
        end else begin
            // Set after clear so an allocate wins over a release of the same tag.
            if (rel_fire)   in_use[rel_idx]   <= 1'b0;
            if (alloc_fire) in_use[alloc_idx] <= 1'b1;
            release_err_q <= release_err_q | rel_bad;
        end
    end
`else
    assign rel_fire    = enabled && is_ready && release_valid;
    assign release_err = 1'b0;
`endif

    assign init_push = (state == ST_INIT) && (init_cnt != CNT_WIDTH'(NUM_TAGS));
    assign push      = init_push || rel_fire;
    assign push_data = init_push ? TAG_WIDTH'(init_cnt) : release_tag;

    assign outstanding_next = outstanding_q + CNT_WIDTH'(alloc_fire) - CNT_WIDTH'(rel_fire);
    assign init_done_next   = init_done_q || (init_push && (init_cnt == CNT_WIDTH'(NUM_TAGS - 1)));

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_INIT;
            ST_INIT:  if (init_cnt == CNT_WIDTH'(NUM_TAGS)) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_RESET;
        endcase
        if (!enabled) state_next = ST_RESET;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) state <= ST_RESET;
        else       state <= state_next;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            head                 <= '0;
            tail                 <= '0;
            free_count           <= '0;
            init_cnt             <= '0;
            outstanding_q        <= '0;
            init_done_q          <= 1'b0;
            idle_q               <= 1'b0;
            release_meta_valid_q <= 1'b0;
        end else if (!enabled) begin
            head                 <= '0;
            tail                 <= '0;
            free_count           <= '0;
            init_cnt             <= '0;
            outstanding_q        <= '0;
            init_done_q          <= 1'b0;
            idle_q               <= 1'b0;
            release_meta_valid_q <= 1'b0;
        end else begin
            if (init_push)  init_cnt <= init_cnt + 1'b1;
            if (alloc_fire) head     <= ptr_inc(head);
            if (push)       tail     <= ptr_inc(tail);
            free_count           <= free_count + CNT_WIDTH'(push) - CNT_WIDTH'(alloc_fire);
            outstanding_q        <= outstanding_next;
            init_done_q          <= init_done_next;
            idle_q               <= init_done_next && (outstanding_next == '0);
            release_meta_valid_q <= rel_fire;
        end
    end

    // Storage arrays carry no reset; contents are only read once written.
    always_ff @(posedge clock) begin
        if (push)       free_list[tail]     <= push_data;
        if (alloc_fire) meta_ram[alloc_idx] <= alloc_meta;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            release_meta <= '0;
            rd_meta      <= '0;
        end else begin
            if (rel_fire) release_meta <= meta_ram[rel_idx];
            rd_meta <= meta_ram[rd_idx];
        end
    end

    assign release_meta_valid = release_meta_valid_q;
    assign outstanding        = outstanding_q;
    assign init_done          = init_done_q;
    assign idle               = idle_q;

endmodule

// File: tb/tb_tag_pool_control.sv
// tb/tb_tag_pool_control.sv - randomized scoreboard bench for tag_pool_control
module tb_tag_pool_control;

    localparam int TW = 8;
    localparam int NT = 256;
    localparam int MW = 32;
    localparam int CW = $clog2(NT + 1);

`ifdef TAG_POOL_RELEASE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rstn = 1'b0;
    logic          enabled = 1'b1;
    logic          alloc_valid = 1'b0;
    logic [MW-1:0] alloc_meta = '0;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          release_valid = 1'b0;
    logic [TW-1:0] release_tag = '0;
    logic          release_meta_valid;
    logic [MW-1:0] release_meta;
    logic [TW-1:0] rd_tag = '0;
    logic [MW-1:0] rd_meta;
    logic [CW-1:0] outstanding;
    logic          init_done;
    logic          idle;
    logic          release_err;

    tag_pool_control #(.TAG_WIDTH(TW), .NUM_TAGS(NT), .META_WIDTH(MW)) dut (
        .clock(clock), .rstn(rstn), .enabled(enabled),
        .alloc_valid(alloc_valid), .alloc_meta(alloc_meta),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .release_valid(release_valid), .release_tag(release_tag),
        .release_meta_valid(release_meta_valid), .release_meta(release_meta),
        .rd_tag(rd_tag), .rd_meta(rd_meta),
        .outstanding(outstanding), .init_done(init_done), .idle(idle),
        .release_err(release_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: free tags as an ordered queue, metadata as a plain array.
    int            free_q[$];
    logic [MW-1:0] meta_m [NT];
    bit            meta_known [NT];
    bit            in_use_m [NT];
    int            out_m = 0;
    bit            init_m = 0;
    bit            rdy_m = 0;
    bit            err_m = 0;

    typedef struct {
        logic [MW-1:0] meta;
        bit            known;
    } rel_exp_t;
    rel_exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        rel_exp_t e;
        if (rstn && release_meta_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_release_meta_valid", release_meta_valid, 0);
            end else begin
                e = sb_q.pop_front();
                if (e.known) check("release_meta", release_meta, e.meta);
            end
        end
    end

    task automatic pick_in_use(output int tag);
        int l[$];
        for (int i = 0; i < NT; i++) if (in_use_m[i]) l.push_back(i);
        tag = (l.size() > 0) ? l[$urandom_range(0, l.size() - 1)] : 0;
    endtask

    task automatic do_cycle(input bit a, input logic [MW-1:0] m, input bit r,
                            input logic [TW-1:0] t, input logic [TW-1:0] rdt);
        bit            ready_m, afire, rfire, rd_known;
        int            tag;
        logic [MW-1:0] rd_exp;
        rel_exp_t      e;
        alloc_valid   = a;
        alloc_meta    = m;
        release_valid = r;
        release_tag   = t;
        rd_tag        = rdt;
        ready_m = rdy_m && (free_q.size() > 0);
        check("alloc_ready", alloc_ready, ready_m);
        if (ready_m) check("alloc_tag", alloc_tag, free_q[0]);
        rd_exp   = meta_m[rdt];
        rd_known = meta_known[rdt];
        afire = a && ready_m;
        rfire = r && rdy_m && (!CHECK_EN || in_use_m[t]);
        if (r && rdy_m && !rfire) err_m = 1;
        if (rfire) begin
            e.meta  = meta_m[t];
            e.known = meta_known[t];
            sb_q.push_back(e);
            in_use_m[t] = 0;
            out_m--;
        end
        if (afire) begin
            tag = free_q.pop_front();
            meta_m[tag] = m;
            meta_known[tag] = 1;
            in_use_m[tag] = 1;
            out_m++;
        end
        if (rfire) free_q.push_back(int'(t));
        @(posedge clock);
        #1;
        check("outstanding", outstanding, out_m);
        check("idle", idle, init_m && out_m == 0);
        check("init_done", init_done, init_m);
        check("release_err", release_err, err_m);
        check("release_meta_valid", release_meta_valid, rfire);
        if (rd_known) check("rd_meta", rd_meta, rd_exp);
    endtask

    task automatic wait_init();
        int t_init = -1;
        int t_rdy = -1;
        for (int n = 1; n <= 400 && t_rdy < 0; n++) begin
            @(posedge clock);
            #1;
            if (init_done && t_init < 0) t_init = n;
            if (alloc_ready) t_rdy = n;
        end
        check("init_done_cycle", t_init, NT + 1);
        check("alloc_ready_cycle", t_rdy, NT + 2);
        free_q.delete();
        for (int i = 0; i < NT; i++) free_q.push_back(i);
        init_m = 1;
        rdy_m  = 1;
    endtask

    initial begin
        int tag;
        bit a, r;
        for (int i = 0; i < NT; i++) begin
            meta_known[i] = 0;
            in_use_m[i] = 0;
            meta_m[i] = '0;
        end

        repeat (3) @(posedge clock);
        #1;
        check("rst_alloc_ready", alloc_ready, 0);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_release_meta_valid", release_meta_valid, 0);
        check("rst_release_meta", release_meta, 0);
        check("rst_rd_meta", rd_meta, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_init_done", init_done, 0);
        check("rst_idle", idle, 0);
        check("rst_release_err", release_err, 0);

        @(negedge clock);
        rstn = 1'b1;
        wait_init();

        // Fill the pool completely; metadata tracks the tag it is bound to.
        for (int i = 0; i < NT; i++)
            do_cycle(1, MW'(free_q[0] + 'h100), 0, '0, TW'($urandom_range(0, NT - 1)));
        do_cycle(1, 32'hDEAD, 0, '0, 8'h07);
        check("full_outstanding", outstanding, NT);
        check("full_idle", idle, 0);

        do_cycle(0, '0, 1, 8'h2A, 8'h2A);
        check("rel2a_outstanding", outstanding, NT - 1);

        // One free tag: allocate it while 0x05 is returned in the same cycle.
        do_cycle(1, 32'hABCD, 1, 8'h05, 8'h05);
        check("same_cycle_outstanding", outstanding, NT - 1);
        do_cycle(0, '0, 0, '0, 8'h2A);

        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(0, 99) < 55;
            r = out_m > 0 && $urandom_range(0, 99) < 45;
            pick_in_use(tag);
            do_cycle(a, $urandom, r, TW'(tag), TW'($urandom_range(0, NT - 1)));
        end

        for (int i = 0; i < 600 && out_m != 40; i++) begin
            pick_in_use(tag);
            if (out_m < 40) do_cycle(1, $urandom, 0, '0, TW'($urandom_range(0, NT - 1)));
            else            do_cycle(0, '0, 1, TW'(tag), TW'($urandom_range(0, NT - 1)));
        end
        check("pre_flush_outstanding", outstanding, 40);

        alloc_valid   = 1'b0;
        release_valid = 1'b0;
        enabled       = 1'b0;
        @(posedge clock);
        #1;
        check("flush_outstanding", outstanding, 0);
        check("flush_init_done", init_done, 0);
        check("flush_idle", idle, 0);
        check("flush_alloc_ready", alloc_ready, 0);
        free_q.delete();
        for (int i = 0; i < NT; i++) in_use_m[i] = 0;
        out_m = 0;
        init_m = 0;
        rdy_m = 0;
        err_m = 0;
        enabled = 1'b1;
        wait_init();

        for (int i = 0; i < 3; i++) begin
            check("reinit_tag_order", alloc_tag, i);
            do_cycle(1, $urandom, 0, '0, TW'(i));
        end

        // Tag 0x10 is free at this point; only the checked build rejects it.
        do_cycle(0, '0, 1, 8'h10, 8'h10);
        check("bogus_release_err", release_err, CHECK_EN);
        do_cycle(0, '0, 0, '0, 8'h00);

        for (int i = 0; i < 10 && out_m > 0; i++) begin
            pick_in_use(tag);
            do_cycle(0, '0, 1, TW'(tag), TW'(tag));
        end
        do_cycle(0, '0, 0, '0, 8'h01);
        check("drained_idle", idle, 1);
        repeat (2) @(posedge clock);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
